// File: rtl/axi_ram_slave.sv
// AXI3-style burst slave backed by a register-array memory with independent read/write engines.
// Define AXI_RAM_WRITE_EN for a writable RAM; leave it undefined for a ROM that still answers write bursts.
`timescale 1ns/1ps
module axi_ram_slave #(
  parameter int    ADDR_WIDTH = 32,
  parameter int    DATA_WIDTH = 32,
  parameter int    ID_WIDTH   = 2,
  parameter int    DEPTH      = 1024,
  parameter string INIT_FILE  = ""
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESET,
  input  logic [ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [3:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [3:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]       S_AXI_RID,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
`ifdef AXI_RAM_WRITE_EN
  localparam bit WRITE_EN_C = 1'b1;
`else
  localparam bit WRITE_EN_C = 1'b0;
`endif

  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  rstate_t               rstate_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [3:0]            rlen_q, rcnt_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;

  wstate_t               wstate_q;
  logic                  awready_q, wready_q, bvalid_q, werr_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q, wresp_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [3:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  wlast_beat_d, wmism_d;

  function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF +: IDXW];
  endfunction

  // WRAP keeps the low bits inside an aligned (len+1)<<size window; reserved encoding behaves as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [3:0] len,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1'b1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1'b1)) << size) - ADDR_WIDTH'(1'b1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  assign raddr_d      = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
  assign waddr_d      = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
  assign wlast_beat_d = (wcnt_q == wlen_q);
  assign wmism_d      = (S_AXI_WLAST != wlast_beat_d);
  assign wresp_d      = (werr_q || wmism_d || !WRITE_EN_C) ? 2'b10 : 2'b00;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= 4'd0;
      rcnt_q    <= 4'd0;
      rsize_q   <= 3'd0;
      rburst_q  <= 2'd0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (S_AXI_ARVALID && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= S_AXI_ARID;
            raddr_q   <= S_AXI_ARADDR;
            rlen_q    <= S_AXI_ARLEN;
            rsize_q   <= S_AXI_ARSIZE;
            rburst_q  <= S_AXI_ARBURST;
            rcnt_q    <= 4'd0;
            rdata_q   <= mem_q[word_idx(S_AXI_ARADDR)];
            rvalid_q  <= 1'b1;
            rlast_q   <= (S_AXI_ARLEN == 4'd0);
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              raddr_q <= raddr_d;
              rdata_q <= mem_q[word_idx(raddr_d)];
              rcnt_q  <= rcnt_q + 4'd1;
              rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
            end
          end
        end
        default: begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
          rstate_q <= R_IDLE;
        end
      endcase
    end
  end

  // The burst always ends after len+1 beats; a WLAST disagreement only poisons the response.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      werr_q    <= 1'b0;
      waddr_q   <= '0;
      wlen_q    <= 4'd0;
      wcnt_q    <= 4'd0;
      wsize_q   <= 3'd0;
      wburst_q  <= 2'd0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (S_AXI_AWVALID && awready_q) begin
            awready_q <= 1'b0;
            bid_q     <= S_AXI_AWID;
            waddr_q   <= S_AXI_AWADDR;
            wlen_q    <= S_AXI_AWLEN;
            wsize_q   <= S_AXI_AWSIZE;
            wburst_q  <= S_AXI_AWBURST;
            wcnt_q    <= 4'd0;
            werr_q    <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID && wready_q) begin
            waddr_q <= waddr_d;
            wcnt_q  <= wcnt_q + 4'd1;
            werr_q  <= werr_q | wmism_d;
            if (wlast_beat_d) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= wresp_d;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: begin
          wready_q <= 1'b0;
          bvalid_q <= 1'b0;
          wstate_q <= W_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_RAM_WRITE_EN
  logic            wr_fire_s;
  logic [IDXW-1:0] widx_s;
  assign wr_fire_s = wready_q && S_AXI_WVALID;
  assign widx_s    = word_idx(waddr_q);

  // Memory has no reset so its contents survive S_AXI_ARESET.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_fire_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (S_AXI_WSTRB[b]) mem_q[widx_s][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{S_AXI_WDATA, S_AXI_WSTRB};
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;

endmodule
